// File: rtl/playback_pkg.sv
// Shared definitions for the playback sequencer.
// Holds the FSM state encoding and the default sizing constants used by
// playback_ctrl and its gap timer.
package playback_pkg;

  localparam int STATE_W            = 2;
  localparam int DEF_NUM_SONGS      = 4;
  localparam int DEF_SONG_SEL_WIDTH = 2;
  localparam int DEF_GAP_CYCLES     = 16;
  localparam int DEF_GAP_WIDTH      = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_PAUSED  = 2'd0,
    ST_PLAYING = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_GAP     = 2'd3
  } pb_state_e;

endpackage

// File: rtl/playback_ctrl_gap_timer.sv
// gap_timer: loadable down-counter with asynchronous active-high reset.
// Ports:
//   clk, reset   - clock and async active-high reset
//   load         - load load_value into the counter (wins over enable)
//   load_value   - value loaded on load
//   enable       - decrement by one when not already zero
//   count        - current counter value
//   zero         - high when count == 0
// Generic enough to time the inter-note gap in the note player as well.
module gap_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/playback_ctrl.sv
// playback_ctrl: top-level playback sequencer for the song_reader.
// Turns play/pause and next-song button pulses plus the reader's song_done
// pulse into a play level, a song select and a one-cycle reset_player flush,
// inserting a silent gap of GAP_CYCLES cycles before resuming playback.
// Ports:
//   clk, reset    - clock and async active-high reset
//   play_button   - one-cycle pulse, toggles play/pause
//   next_button   - one-cycle pulse, skip to next song
//   song_done     - one-cycle pulse from song_reader at end of song
//   play          - high only while playing
//   song          - current song select
//   reset_player  - one-cycle flush of song_reader and note player
//   gap_active    - high while in the inter-song gap
// Build option: define PLAYBACK_AUTO_ADVANCE_EN to make song_done advance to
// the next song and keep playing; undefined, song_done rewinds and pauses.
module playback_ctrl
  import playback_pkg::*;
#(
  parameter int NUM_SONGS      = DEF_NUM_SONGS,
  parameter int SONG_SEL_WIDTH = DEF_SONG_SEL_WIDTH,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int GAP_WIDTH      = DEF_GAP_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play_button,
  input  logic                      next_button,
  input  logic                      song_done,
  output logic                      play,
  output logic [SONG_SEL_WIDTH-1:0] song,
  output logic                      reset_player,
  output logic                      gap_active
);

  localparam logic [SONG_SEL_WIDTH-1:0] LAST_SONG = SONG_SEL_WIDTH'(NUM_SONGS - 1);
  // Counter runs GAP_CYCLES-1 .. 0, giving exactly GAP_CYCLES cycles in GAP.
  localparam logic [GAP_WIDTH-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_WIDTH'(GAP_CYCLES - 1) : '0;

  pb_state_e                 state_q, state_d;
  logic [SONG_SEL_WIDTH-1:0] song_q, song_d;
  logic                      resume_q, resume_d;
  logic [SONG_SEL_WIDTH-1:0] song_next;
  logic                      tmr_load, tmr_en, tmr_zero;
  logic [GAP_WIDTH-1:0]      gap_count;
  logic                      gap_count_unused;

  // Wrap against NUM_SONGS-1 so non-power-of-two song counts work.
  assign song_next = (song_q == LAST_SONG) ? '0 : song_q + SONG_SEL_WIDTH'(1);

  gap_timer #(
    .WIDTH(GAP_WIDTH)
  ) u_gap (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_value(GAP_LOAD),
    .enable    (tmr_en),
    .count     (gap_count),
    .zero      (tmr_zero)
  );

  // The raw count is only of interest for debug; the FSM uses zero.
  assign gap_count_unused = ^gap_count;

  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    resume_d = resume_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      ST_PAUSED: begin
        if (next_button) begin
          state_d  = ST_FLUSH;
          song_d   = song_next;
          resume_d = 1'b0;
        end else if (play_button) begin
          state_d = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (next_button) begin
          // Also covers next_button with song_done: a single advance.
          state_d  = ST_FLUSH;
          song_d   = song_next;
          resume_d = 1'b1;
        end else if (song_done) begin
          state_d  = ST_FLUSH;
`ifdef PLAYBACK_AUTO_ADVANCE_EN
          song_d   = song_next;
          resume_d = 1'b1;
`else
          resume_d = 1'b0;
`endif
        end else if (play_button) begin
          state_d = ST_PAUSED;
        end
      end
      ST_FLUSH: begin
        if (!resume_q) begin
          state_d = ST_PAUSED;
        end else if (GAP_CYCLES == 0) begin
          state_d = ST_PLAYING;
        end else begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
        end
      end
      ST_GAP: begin
        if (next_button) begin
          state_d = ST_FLUSH;
          song_d  = song_next;
        end else if (play_button) begin
          state_d  = ST_PAUSED;
          resume_d = 1'b0;
        end else if (tmr_zero) begin
          state_d = ST_PLAYING;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_PAUSED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_PAUSED;
      song_q   <= '0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      resume_q <= resume_d;
    end
  end

  assign play         = (state_q == ST_PLAYING);
  assign reset_player = (state_q == ST_FLUSH);
  assign gap_active   = (state_q == ST_GAP);
  assign song         = song_q;

endmodule

// File: tb/tb_playback_ctrl.sv
module tb_playback_ctrl;

  localparam int NS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_button, next_button, song_done;
  logic       play16, rp16, gap16;
  logic [1:0] song16;
  logic       play0, rp0, gap0;
  logic [1:0] song0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  playback_ctrl #(.NUM_SONGS(4), .SONG_SEL_WIDTH(2), .GAP_CYCLES(16), .GAP_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
    .song_done(song_done), .play(play16), .song(song16), .reset_player(rp16),
    .gap_active(gap16));

  playback_ctrl #(.NUM_SONGS(4), .SONG_SEL_WIDTH(2), .GAP_CYCLES(0), .GAP_WIDTH(8)) dut0 (
    .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
    .song_done(song_done), .play(play0), .song(song0), .reset_player(rp0),
    .gap_active(gap0));

  // Behavioural model: what the listener experiences, not the FSM.
  typedef struct {
    bit play;
    bit flush;
    bit resume;
    int gap_left;
    int song;
  } mdl_t;

  mdl_t m16, m0;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.play = 0; r.flush = 0; r.resume = 0; r.gap_left = 0; r.song = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t s, int g, logic nb, logic pb, logic sd);
    mdl_t r = s;
    if (s.flush) begin
      r.flush = 0;
      if (s.resume) begin
        if (g == 0) r.play = 1;
        else        r.gap_left = g;
      end
    end else if (s.gap_left > 0) begin
      if (nb) begin
        r.gap_left = 0; r.flush = 1; r.song = (s.song + 1) % NS;
      end else if (pb) begin
        r.gap_left = 0; r.resume = 0;
      end else begin
        r.gap_left = s.gap_left - 1;
        if (r.gap_left == 0) r.play = 1;
      end
    end else if (s.play) begin
      if (nb) begin
        r.play = 0; r.flush = 1; r.song = (s.song + 1) % NS; r.resume = 1;
      end else if (sd) begin
        r.play = 0; r.flush = 1;
`ifdef PLAYBACK_AUTO_ADVANCE_EN
        r.song = (s.song + 1) % NS; r.resume = 1;
`else
        r.resume = 0;
`endif
      end else if (pb) begin
        r.play = 0;
      end
    end else begin
      if (nb) begin
        r.flush = 1; r.song = (s.song + 1) % NS; r.resume = 0;
      end else if (pb) begin
        r.play = 1;
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m16 = mdl_reset();
      m0  = mdl_reset();
    end else begin
      m16 = step(m16, 16, next_button, play_button, song_done);
      m0  = step(m0, 0, next_button, play_button, song_done);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("g16.play", int'(play16), int'(m16.play));
      chk("g16.reset_player", int'(rp16), int'(m16.flush));
      chk("g16.gap_active", int'(gap16), int'(m16.gap_left > 0));
      chk("g16.song", int'(song16), m16.song);
      chk("g0.play", int'(play0), int'(m0.play));
      chk("g0.reset_player", int'(rp0), int'(m0.flush));
      chk("g0.gap_active", int'(gap0), int'(m0.gap_left > 0));
      chk("g0.song", int'(song0), m0.song);
    end
  end

  task automatic pulse(input logic nb, input logic pb, input logic sd);
    next_button = nb; play_button = pb; song_done = sd;
    @(posedge clk); #1;
    next_button = 0; play_button = 0; song_done = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset = 1; play_button = 0; next_button = 0; song_done = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst.play", int'(play16), 0);
    chk("rst.song", int'(song16), 0);
    chk("rst.reset_player", int'(rp16), 0);
    chk("rst.gap_active", int'(gap16), 0);

    // Play from reset.
    idle(3);
    pulse(0, 1, 0);
    chk("play.play", int'(play16), 1);
    chk("play.song", int'(song16), 0);

    // Advance through songs to 3; dut0 resumes right after FLUSH.
    pulse(1, 0, 0);
    chk("next1.rp", int'(rp16), 1);
    chk("next1.song", int'(song16), 1);
    idle(1);
    chk("g0.direct_play", int'(play0), 1);
    chk("g0.no_gap", int'(gap0), 0);
    idle(20);
    pulse(1, 0, 0); idle(20);
    pulse(1, 0, 0); idle(20);
    chk("song3.play", int'(play16), 1);
    chk("song3.song", int'(song16), 3);

    // Wrap 3 -> 0 with a 16-cycle gap.
    pulse(1, 0, 0);
    chk("wrap.rp", int'(rp16), 1);
    chk("wrap.song", int'(song16), 0);
    idle(1);
    chk("wrap.gap_first", int'(gap16), 1);
    idle(15);
    chk("wrap.gap_last", int'(gap16), 1);
    chk("wrap.play_in_gap", int'(play16), 0);
    idle(1);
    chk("wrap.resumed", int'(play16), 1);
    chk("wrap.gap_end", int'(gap16), 0);

    // song_done on song 1.
    pulse(1, 0, 0); idle(20);
    pulse(0, 0, 1);
    chk("done.rp", int'(rp16), 1);
`ifdef PLAYBACK_AUTO_ADVANCE_EN
    chk("done.song", int'(song16), 2);
    idle(1);
    chk("done.gap", int'(gap16), 1);
    idle(20);
    chk("done.replay", int'(play16), 1);
`else
    chk("done.song", int'(song16), 1);
    idle(1);
    chk("done.paused", int'(play16), 0);
    chk("done.no_gap", int'(gap16), 0);
    idle(20);
    chk("done.still_paused", int'(play16), 0);
    pulse(0, 1, 0);
`endif

    // next_button together with song_done: single advance, single flush.
    pulse(1, 0, 1);
    chk("both.rp", int'(rp16), 1);
`ifdef PLAYBACK_AUTO_ADVANCE_EN
    chk("both.song", int'(song16), 3);
`else
    chk("both.song", int'(song16), 2);
`endif
    idle(1);
    chk("both.rp_once", int'(rp16), 0);
    idle(20);

    // play_button at gap count 7 cancels resume.
    pulse(1, 0, 0);
    idle(9);
    chk("gap7.count", int'(dut.u_gap.count), 7);
    chk("gap7.gap", int'(gap16), 1);
    pulse(0, 1, 0);
    chk("gap7.gap_off", int'(gap16), 0);
    chk("gap7.play", int'(play16), 0);
    idle(3);
    chk("gap7.stays", int'(play16), 0);
    pulse(0, 1, 0);
    chk("gap7.replay", int'(play16), 1);

    // Asynchronous reset mid-GAP.
    pulse(1, 0, 0);
    idle(4);
    #2 reset = 1;
    #1;
    chk("arst.gap", int'(gap16), 0);
    chk("arst.play", int'(play16), 0);
    chk("arst.rp", int'(rp16), 0);
    chk("arst.song", int'(song16), 0);
    chk("arst.g0.play", int'(play0), 0);
    @(posedge clk); #1 reset = 0;

    // Asynchronous reset mid-FLUSH.
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    chk("fl.rp_before", int'(rp16), 1);
    #2 reset = 1;
    #1;
    chk("fl.rp", int'(rp16), 0);
    chk("fl.song", int'(song16), 0);
    chk("fl.g0.rp", int'(rp0), 0);
    @(posedge clk); #1 reset = 0;
    idle(5);

    // No-gap build: FLUSH straight into PLAYING.
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    chk("g0.flush", int'(rp0), 1);
    chk("g0.flush_song", int'(song0), 1);
    idle(1);
    chk("g0.play_after", int'(play0), 1);
    chk("g0.rp_after", int'(rp0), 0);
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
